// File: rtl/keypad_digit_register.sv
// keypad_digit_register
// ---------------------
// Receiving end of the keypad encoder link. The asynchronous active-low
// key strobe (loadn) and its BCD digit are synchronised together, the
// strobe is debounced for both press and release, and each qualified press
// contributes at most one digit. Accepted digits shift right-to-left through
// a four-digit MM:SS entry register.
//
// Ports
//   clk           system clock, rising edge
//   resetn        asynchronous active-low reset
//   BCD_IN[3:0]   encoder digit, meaningful while loadn is low
//   loadn         encoder key-valid strobe, active low, asynchronous
//   enablen       entry enable, active low
//   clearn        synchronous active-low clear of the entry register
//   min_tens, min_ones, sec_tens, sec_ones [3:0]   entry digits
//   digit_count[2:0]  digits accepted since the last clear (0..4)
//   digit_strobe  one-cycle pulse when the digits update
//   full          digit_count == 4
//   nonzero       any entry digit is non-zero
module keypad_digit_register #(
  parameter int HOLD_CYCLES = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] BCD_IN,
  input  logic       loadn,
  input  logic       enablen,
  input  logic       clearn,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [2:0] digit_count,
  output logic       digit_strobe,
  output logic       full,
  output logic       nonzero
);

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_QUAL,
    ACCEPT,
    WAIT_RELEASE,
    REL_QUAL
  } state_t;

  // Synchroniser chains. prime_* tracks how far genuine samples have
  // propagated since reset, so the FSM can tell the reset value of the
  // loadn chain apart from a real "key up" observation.
  logic [SYNC_STAGES-1:0] loadn_sync_q, loadn_sync_d;
  logic [SYNC_STAGES-1:0] prime_q, prime_d;
  logic [3:0]             bcd_sync_q [SYNC_STAGES];
  logic [3:0]             bcd_sync_d [SYNC_STAGES];

  logic       loadn_s;
  logic [3:0] bcd_s;
  logic       primed;

  state_t     state_q, state_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [7:0] cnt_inc;
  logic       armed_q, armed_d;
  logic       accept;

  logic [3:0] min_tens_q, min_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic [2:0] digit_count_q, digit_count_d;
  logic       digit_strobe_q, digit_strobe_d;
  logic       full_q, full_d;
  logic       nonzero_q, nonzero_d;

  assign loadn_s = loadn_sync_q[SYNC_STAGES-1];
  assign bcd_s   = bcd_sync_q[SYNC_STAGES-1];
  assign primed  = prime_q[SYNC_STAGES-1];
  assign cnt_inc = hold_cnt_q + 8'd1;

  // loadn and BCD_IN move through identical chains so they stay aligned.
  always_comb begin
    loadn_sync_d  = {loadn_sync_q[SYNC_STAGES-2:0], loadn};
    prime_d       = {prime_q[SYNC_STAGES-2:0], 1'b1};
    bcd_sync_d[0] = BCD_IN;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      bcd_sync_d[i] = bcd_sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      loadn_sync_q <= '1;
      prime_q      <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        bcd_sync_q[i] <= 4'd0;
      end
    end else begin
      loadn_sync_q <= loadn_sync_d;
      prime_q      <= prime_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        bcd_sync_q[i] <= bcd_sync_d[i];
      end
    end
  end

  // Debounce FSM: next state, hold counter and the accept decision.
  // armed_q is clear after reset until a qualified release has been seen,
  // so a key held through reset is not taken as a fresh press; until then
  // IDLE behaves like the release-tracking states.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    armed_d    = armed_q;
    accept     = 1'b0;

    case (state_q)
      IDLE: begin
        hold_cnt_d = 8'd0;
        if (primed) begin
          if (!armed_q) begin
            if (!loadn_s) begin
              state_d = WAIT_RELEASE;
            end else if (HOLD_LIM <= 8'd1) begin
              armed_d = 1'b1;
            end else begin
              state_d    = REL_QUAL;
              hold_cnt_d = 8'd1;
            end
          end else if (!loadn_s) begin
            if (HOLD_LIM <= 8'd1) begin
              state_d = ACCEPT;
            end else begin
              state_d    = PRESS_QUAL;
              hold_cnt_d = 8'd1;
            end
          end
        end
      end

      PRESS_QUAL: begin
        if (loadn_s) begin
          state_d    = IDLE;
          hold_cnt_d = 8'd0;
        end else if (cnt_inc >= HOLD_LIM) begin
          state_d    = ACCEPT;
          hold_cnt_d = 8'd0;
        end else begin
          hold_cnt_d = cnt_inc;
        end
      end

      ACCEPT: begin
        accept     = !enablen && (bcd_s <= 4'd9) && (digit_count_q < 3'd4);
        state_d    = WAIT_RELEASE;
        hold_cnt_d = 8'd0;
      end

      WAIT_RELEASE: begin
        hold_cnt_d = 8'd0;
        if (loadn_s) begin
          if (HOLD_LIM <= 8'd1) begin
            state_d = IDLE;
            armed_d = 1'b1;
          end else begin
            state_d    = REL_QUAL;
            hold_cnt_d = 8'd1;
          end
        end
      end

      REL_QUAL: begin
        if (!loadn_s) begin
          state_d    = WAIT_RELEASE;
          hold_cnt_d = 8'd0;
        end else if (cnt_inc >= HOLD_LIM) begin
          state_d    = IDLE;
          hold_cnt_d = 8'd0;
          armed_d    = 1'b1;
        end else begin
          hold_cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d    = IDLE;
        hold_cnt_d = 8'd0;
      end
    endcase

    // Clear overrides everything; a key still down must be released first.
    if (!clearn) begin
      accept     = 1'b0;
      hold_cnt_d = 8'd0;
      state_d    = loadn_s ? IDLE : WAIT_RELEASE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      hold_cnt_q <= 8'd0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      armed_q    <= armed_d;
    end
  end

  // Entry register: shift left by one digit on accept. full and nonzero
  // are derived from the next-state values so they move with the digits.
  always_comb begin
    min_tens_d     = min_tens_q;
    min_ones_d     = min_ones_q;
    sec_tens_d     = sec_tens_q;
    sec_ones_d     = sec_ones_q;
    digit_count_d  = digit_count_q;
    digit_strobe_d = 1'b0;

    if (!clearn) begin
      min_tens_d    = 4'd0;
      min_ones_d    = 4'd0;
      sec_tens_d    = 4'd0;
      sec_ones_d    = 4'd0;
      digit_count_d = 3'd0;
    end else if (accept) begin
      min_tens_d     = min_ones_q;
      min_ones_d     = sec_tens_q;
      sec_tens_d     = sec_ones_q;
      sec_ones_d     = bcd_s;
      digit_count_d  = digit_count_q + 3'd1;
      digit_strobe_d = 1'b1;
    end

    full_d    = (digit_count_d == 3'd4);
    nonzero_d = |{min_tens_d, min_ones_d, sec_tens_d, sec_ones_d};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      min_tens_q     <= 4'd0;
      min_ones_q     <= 4'd0;
      sec_tens_q     <= 4'd0;
      sec_ones_q     <= 4'd0;
      digit_count_q  <= 3'd0;
      digit_strobe_q <= 1'b0;
      full_q         <= 1'b0;
      nonzero_q      <= 1'b0;
    end else begin
      min_tens_q     <= min_tens_d;
      min_ones_q     <= min_ones_d;
      sec_tens_q     <= sec_tens_d;
      sec_ones_q     <= sec_ones_d;
      digit_count_q  <= digit_count_d;
      digit_strobe_q <= digit_strobe_d;
      full_q         <= full_d;
      nonzero_q      <= nonzero_d;
    end
  end

  assign min_tens     = min_tens_q;
  assign min_ones     = min_ones_q;
  assign sec_tens     = sec_tens_q;
  assign sec_ones     = sec_ones_q;
  assign digit_count  = digit_count_q;
  assign digit_strobe = digit_strobe_q;
  assign full         = full_q;
  assign nonzero      = nonzero_q;

endmodule

// File: tb/tb_keypad_digit_register.sv
// tb_keypad_digit_register
// Self-checking bench for keypad_digit_register. A press-level model holds
// the four entry digits in an array and applies the acceptance rules per
// key press; directed scenarios plus a randomized press sequence drive it.
module tb_keypad_digit_register;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] BCD_IN;
  logic       loadn;
  logic       enablen;
  logic       clearn;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [2:0] digit_count;
  logic       digit_strobe, full, nonzero;

  keypad_digit_register #(.HOLD_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .resetn(resetn), .BCD_IN(BCD_IN), .loadn(loadn),
    .enablen(enablen), .clearn(clearn),
    .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones),
    .digit_count(digit_count), .digit_strobe(digit_strobe),
    .full(full), .nonzero(nonzero)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference model: m_dig[0] is minutes tens ... m_dig[3] seconds ones.
  int m_dig[4];
  int m_cnt;

  wire [20:0] dut_vec = {min_tens, min_ones, sec_tens, sec_ones,
                         digit_count, full, nonzero};

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
    m_cnt = 0;
  endfunction

  function automatic bit model_press(input int d, input bit en_n);
    if (!en_n && d <= 9 && m_cnt < 4) begin
      for (int i = 0; i < 3; i++) m_dig[i] = m_dig[i+1];
      m_dig[3] = d;
      m_cnt++;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [20:0] model_vec();
    bit nz;
    nz = (m_dig[0] != 0) || (m_dig[1] != 0) || (m_dig[2] != 0) || (m_dig[3] != 0);
    return {4'(m_dig[0]), 4'(m_dig[1]), 4'(m_dig[2]), 4'(m_dig[3]),
            3'(m_cnt), (m_cnt == 4), nz};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clearn = 1'b0;
    tick();
    clearn = 1'b1;
    tick();
    model_clear();
  endtask

  // Hold a key for 'hold' cycles then release for 'rel' cycles, counting strobes.
  task automatic do_press(input logic [3:0] d, input int hold, input int rel,
                          output int strobes);
    strobes = 0;
    BCD_IN  = d;
    loadn   = 1'b0;
    repeat (hold) begin
      tick();
      if (digit_strobe === 1'b1) strobes++;
    end
    loadn  = 1'b1;
    BCD_IN = 4'($urandom_range(0, 15));
    repeat (rel) begin
      tick();
      if (digit_strobe === 1'b1) strobes++;
    end
  endtask

  task automatic test_reset();
    resetn  = 1'b0;
    loadn   = 1'b1;
    BCD_IN  = 4'd0;
    enablen = 1'b0;
    clearn  = 1'b1;
    model_clear();
    repeat (3) tick();
    nvec++;
    if (dut_vec !== 21'd0 || digit_strobe !== 1'b0) begin
      nerr++;
      $display("[TB] FAIL reset_state: got %h/%b expected 0/0", dut_vec, digit_strobe);
    end
    resetn = 1'b1;
    repeat (10) tick();
    nvec++;
    if (dut_vec !== model_vec()) begin
      nerr++;
      $display("[TB] FAIL post_reset_idle: got %h expected %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_latency_entry();
    int first;
    int s;
    logic [3:0] seq [4];
    seq[0] = 4'd1; seq[1] = 4'd2; seq[2] = 4'd3; seq[3] = 4'd0;
    first  = 0;
    BCD_IN = seq[0];
    loadn  = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (digit_strobe === 1'b1 && first == 0) first = k;
    end
    loadn = 1'b1;
    repeat (10) tick();
    void'(model_press(1, 1'b0));
    nvec++;
    if (first != 7) begin
      nerr++;
      $display("[TB] FAIL strobe_latency: got edge %0d expected edge 7", first);
    end
    nvec++;
    if (dut_vec !== model_vec()) begin
      nerr++;
      $display("[TB] FAIL first_digit: got %h expected %h", dut_vec, model_vec());
    end
    for (int i = 1; i < 4; i++) begin
      do_press(seq[i], 10, 10, s);
      void'(model_press(int'(seq[i]), 1'b0));
      nvec++;
      if (s != 1 || dut_vec !== model_vec()) begin
        nerr++;
        $display("[TB] FAIL entry_digit%0d: got %h strobes %0d expected %h strobes 1",
                 i, dut_vec, s, model_vec());
      end
    end
    nvec++;
    if (dut_vec !== {4'd1, 4'd2, 4'd3, 4'd0, 3'd4, 1'b1, 1'b1}) begin
      nerr++;
      $display("[TB] FAIL entry_12_30: got %h expected %h", dut_vec,
               {4'd1, 4'd2, 4'd3, 4'd0, 3'd4, 1'b1, 1'b1});
    end
  endtask

  task automatic test_overflow_invalid();
    int s;
    do_press(4'd7, 10, 10, s);
    nvec++;
    if (s != 0 || dut_vec !== model_vec()) begin
      nerr++;
      $display("[TB] FAIL overflow_press: got %h strobes %0d expected %h strobes 0",
               dut_vec, s, model_vec());
    end
    pulse_clear();
    nvec++;
    if (dut_vec !== 21'd0) begin
      nerr++;
      $display("[TB] FAIL clear_idle: got %h expected 0", dut_vec);
    end
    do_press(4'd12, 10, 10, s);
    nvec++;
    if (s != 0 || dut_vec !== 21'd0) begin
      nerr++;
      $display("[TB] FAIL invalid_digit: got %h strobes %0d expected 0 strobes 0", dut_vec, s);
    end
  endtask

  task automatic test_glitch();
    int s;
    s = 0;
    BCD_IN = 4'd5;
    loadn  = 1'b0;
    repeat (3) begin tick(); if (digit_strobe === 1'b1) s++; end
    loadn = 1'b1;
    repeat (2) begin tick(); if (digit_strobe === 1'b1) s++; end
    loadn = 1'b0;
    repeat (20) begin tick(); if (digit_strobe === 1'b1) s++; end
    loadn = 1'b1;
    repeat (10) begin tick(); if (digit_strobe === 1'b1) s++; end
    void'(model_press(5, 1'b0));
    nvec++;
    if (s != 1 || dut_vec !== model_vec()) begin
      nerr++;
      $display("[TB] FAIL glitch: got %h strobes %0d expected %h strobes 1",
               dut_vec, s, model_vec());
    end
  endtask

  task automatic test_enable();
    int s;
    s = 0;
    enablen = 1'b1;
    BCD_IN  = 4'd4;
    loadn   = 1'b0;
    repeat (10) begin tick(); if (digit_strobe === 1'b1) s++; end
    enablen = 1'b0;
    repeat (10) begin tick(); if (digit_strobe === 1'b1) s++; end
    loadn = 1'b1;
    repeat (10) begin tick(); if (digit_strobe === 1'b1) s++; end
    nvec++;
    if (s != 0 || dut_vec !== model_vec()) begin
      nerr++;
      $display("[TB] FAIL disabled_press: got %h strobes %0d expected %h strobes 0",
               dut_vec, s, model_vec());
    end
    do_press(4'd4, 10, 10, s);
    void'(model_press(4, 1'b0));
    nvec++;
    if (s != 1 || dut_vec !== model_vec()) begin
      nerr++;
      $display("[TB] FAIL reenabled_press: got %h strobes %0d expected %h strobes 1",
               dut_vec, s, model_vec());
    end
  endtask

  task automatic test_clear_in_accept();
    int s;
    int d;
    pulse_clear();
    for (int i = 0; i < 2; i++) begin
      d = int'($urandom_range(1, 9));
      do_press(4'(d), 10, 10, s);
      void'(model_press(d, 1'b0));
    end
    s = 0;
    BCD_IN = 4'd9;
    loadn  = 1'b0;
    repeat (6) begin tick(); if (digit_strobe === 1'b1) s++; end
    clearn = 1'b0;
    tick();
    if (digit_strobe === 1'b1) s++;
    clearn = 1'b1;
    model_clear();
    nvec++;
    if (dut_vec !== model_vec()) begin
      nerr++;
      $display("[TB] FAIL clear_in_accept: got %h expected %h", dut_vec, model_vec());
    end
    repeat (10) begin tick(); if (digit_strobe === 1'b1) s++; end
    loadn = 1'b1;
    repeat (10) begin tick(); if (digit_strobe === 1'b1) s++; end
    nvec++;
    if (s != 0 || dut_vec !== 21'd0) begin
      nerr++;
      $display("[TB] FAIL held_after_clear: got %h strobes %0d expected 0 strobes 0", dut_vec, s);
    end
    do_press(4'd6, 10, 10, s);
    void'(model_press(6, 1'b0));
    nvec++;
    if (s != 1 || dut_vec !== model_vec()) begin
      nerr++;
      $display("[TB] FAIL repress_after_clear: got %h strobes %0d expected %h strobes 1",
               dut_vec, s, model_vec());
    end
  endtask

  task automatic test_reset_mid_press();
    int s;
    int d;
    pulse_clear();
    for (int i = 0; i < 3; i++) begin
      d = int'($urandom_range(1, 9));
      do_press(4'(d), 10, 10, s);
      void'(model_press(d, 1'b0));
    end
    BCD_IN = 4'd8;
    loadn  = 1'b0;
    repeat (4) tick();
    resetn = 1'b0;
    #1;
    model_clear();
    nvec++;
    if (dut_vec !== 21'd0 || digit_strobe !== 1'b0) begin
      nerr++;
      $display("[TB] FAIL async_reset: got %h/%b expected 0/0", dut_vec, digit_strobe);
    end
    repeat (2) tick();
    resetn = 1'b1;
    s = 0;
    repeat (20) begin tick(); if (digit_strobe === 1'b1) s++; end
    loadn = 1'b1;
    repeat (10) begin tick(); if (digit_strobe === 1'b1) s++; end
    nvec++;
    if (s != 0 || dut_vec !== 21'd0) begin
      nerr++;
      $display("[TB] FAIL held_through_reset: got %h strobes %0d expected 0 strobes 0", dut_vec, s);
    end
    do_press(4'd8, 10, 10, s);
    void'(model_press(8, 1'b0));
    nvec++;
    if (s != 1 || dut_vec !== model_vec()) begin
      nerr++;
      $display("[TB] FAIL repress_after_reset: got %h strobes %0d expected %h strobes 1",
               dut_vec, s, model_vec());
    end
  endtask

  task automatic test_random();
    int s;
    int d;
    bit en_n;
    bit acc;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 5) == 0) pulse_clear();
      en_n    = ($urandom_range(0, 3) == 0);
      enablen = en_n;
      d       = int'($urandom_range(0, 15));
      do_press(4'(d), int'($urandom_range(6, 12)), int'($urandom_range(6, 12)), s);
      acc = model_press(d, en_n);
      nvec++;
      if (s != int'(acc) || dut_vec !== model_vec()) begin
        nerr++;
        $display("[TB] FAIL random_press%0d: digit %0d en_n %0b got %h strobes %0d expected %h strobes %0d",
                 n, d, en_n, dut_vec, s, model_vec(), acc);
      end
    end
    enablen = 1'b0;
  endtask

  initial begin
    $display("[TB] keypad_digit_register bench start");
    test_reset();
    test_latency_entry();
    test_overflow_invalid();
    test_glitch();
    test_enable();
    test_clear_in_accept();
    test_reset_mid_press();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
